axi2ahb_wdata_buf: RTL and testbench
====================================

AXI2AHB_WDATA_BUF -- requirements
Module: axi2ahb_wdata_buf

Interface
REQ-001 SHALL provide parameter AXI_ID_WIDTH, default 1, width of the AXI write ID.
REQ-002 SHALL provide parameter AXI_DATA_WIDTH, default 32, data width (32/64/128); strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL provide parameter WDATA_DEPTH, default 8, depth of the write-beat FIFO (power of 2, ≥2).
REQ-004 SHALL provide parameter ID_DEPTH, default 4, depth of the pending-ID queue (power of 2, ≥2).
REQ-005 SHALL provide parameter B_DEPTH, default 2, depth of the write-response FIFO (power of 2, ≥2).
REQ-006 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
  ACLK  in  1  clock
  ARESETN  in  1  asynchronous active-low reset
  WDATA  in  AXI_DATA_WIDTH  AXI write data
  WSTRB  in  AXI_DATA_WIDTH/8  AXI write strobe
  WLAST  in  1  last beat of burst
  WVALID  in  1  W valid
  WREADY  out  1  W ready
  BID  out  AXI_ID_WIDTH  response ID
  BRESP  out  2  response code
  BVALID  out  1  B valid
  BREADY  in  1  B ready
  HWDATA  out  AXI_DATA_WIDTH  AHB write data (data phase)
  HREADY  in  1  AHB transfer done
  HRESP  in  1  AHB error (AHB-Lite, 1 = ERROR)
  cmd_id  in  AXI_ID_WIDTH  ID of accepted AW burst
  cmd_valid  in  1  push cmd_id
  cmd_ready  out  1  ID queue not full
  ctrl_wdata_strb  out  AXI_DATA_WIDTH/8  strobe of head beat
  ctrl_wdata_last  out  1  head beat is burst last
  ctrl_wdata_valid  out  1  head beat available to issue
  ctrl_wdata_ready  in  1  controller issues head beat as AHB address phase this cycle (already qualified with HREADY)

Function
REQ-007 W beat accepted when WVALID&&WREADY; stores {WDATA,WSTRB,WLAST}; WREADY = beat FIFO not full (combinational from registered count).
REQ-008 cmd_ready = ID queue not full; push on cmd_valid&&cmd_ready; simultaneous push and pop on a full queue SHALL be allowed only if not full before pop (no bypass).
REQ-009 Pop of beat FIFO SHALL occur on ctrl_wdata_valid&&ctrl_wdata_ready; ctrl_wdata_strb/last reflect head entry.
REQ-010 ctrl_wdata_valid = beat FIFO not empty AND (mid-burst OR free B slots > bursts in flight); in-flight = bursts with ≥1 beat popped and final data phase not complete (0..2).
REQ-011 On pop at cycle t, HWDATA SHALL present popped data from t+1 and hold until the data phase completes (first cycle with HREADY=1 while data phase valid).
REQ-012 Data-phase register: set on pop, cleared on completion without simultaneous pop; pop in completing cycle loads next beat, zero bubble.
REQ-013 Error flag: set when data phase completes with HRESP=1; cleared when the burst's B entry is pushed; HRESP ignored when HREADY=0 or no data phase.
REQ-014 On completion of a beat with last=1: pop ID queue head, push {id, err?2'b10:2'b00} into B FIFO in the same cycle; response latency SHALL be 1 cycle (BVALID at t+1).
REQ-015 BVALID = B FIFO not empty; BID/BRESP head entry; pop on BVALID&&BREADY; BRESP never 2'b01/2'b11.
REQ-016 Data-phase last with empty ID queue is a protocol violation; SHALL not push B and SHALL hold data phase until ID arrives (ID pushed same cycle counts).
REQ-017 Beat FIFO full and empty simultaneously push/pop: full -> pop only; empty -> push only (no bypass); counts never wrap.

Reset
REQ-018 ARESETN low SHALL asynchronously clear all FIFO pointers/counts, data-phase valid, error flag, in-flight count.
REQ-019 Reset values: WREADY=0 while ARESETN low, 1 from first clock after release; cmd_ready same; BVALID=0, ctrl_wdata_valid=0, ctrl_wdata_last=0, ctrl_wdata_strb=0, HWDATA=0, BID=0, BRESP=0.
REQ-020 Reset mid-burst SHALL discard all buffered beats, IDs and responses; no B issued for them.

Structure
REQ-021 Package axi2ahb_pkg SHALL hold BRESP constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and HRESP encoding.
REQ-022 Sub-module axi2ahb_sfifo (parametrised width/depth, count, full/empty) SHALL be instantiated three times: beats, IDs, responses.

Verification
REQ-023 4-beat burst, ID=1, HREADY=1, HRESP=0 -> HWDATA sequence matches, BVALID one cycle after last completion, BID=1, BRESP=00.
REQ-024 Same burst, HRESP=1 on beat 2 (HREADY=1) -> BRESP=10; next burst OKAY (flag cleared).
REQ-025 HREADY low 3 cycles on beat 3 -> HWDATA stable for 4 cycles, no pop until completion.
REQ-026 WDATA_DEPTH=8, 10 beats sent, ctrl_wdata_ready=0 -> WREADY drops after 8 beats, resumes after one pop.
REQ-027 BREADY=0, B_DEPTH=2, three 1-beat bursts -> third burst ctrl_wdata_valid held 0 until B pop.
REQ-028 ARESETN asserted mid-burst -> all outputs at reset values same cycle; no BVALID after release.

Source files
------------

// File: rtl/axi2ahb_pkg.sv
// Shared constants for the AXI-to-AHB write-data buffer.
//   RESP_*  : AXI BRESP encodings produced by the buffer
//   HRESP_* : AHB-Lite HRESP encodings sampled by the buffer
package axi2ahb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // A burst reports SLVERR if any of its data phases returned ERROR.
    function automatic logic [1:0] bresp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi2ahb_sfifo.sv
// Synchronous FIFO, power-of-2 depth, no bypass.
//   gclk/grst_n : clock, async active-low reset (clears pointers/count)
//   push/wdata  : write port, ignored when full
//   pop/rdata   : read port, rdata is the head entry, pop ignored when empty
//   count       : occupancy, full/empty flags
module axi2ahb_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       gclk,
    input  logic                       grst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Full: a pop cannot free room for a same-cycle push. Empty: a push
    // cannot be popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi2ahb_wdata_buf.sv
// AXI W/B side of an AXI-to-AHB write bridge.
//   W channel   : WDATA/WSTRB/WLAST buffered in a beat FIFO (WREADY = not full)
//   cmd_*       : AW IDs queued in order, one per burst
//   ctrl_wdata_*: head beat offered to the AHB controller; a pop starts the
//                 AHB address phase, the beat is then driven on HWDATA
//   HREADY/HRESP: AHB data-phase completion and error
//   B channel   : {BID, BRESP} queued per completed burst
module axi2ahb_wdata_buf
    import axi2ahb_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int WDATA_DEPTH    = 8,
    parameter int ID_DEPTH       = 4,
    parameter int B_DEPTH        = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    output logic [AXI_DATA_WIDTH-1:0]   HWDATA,
    input  logic                        HREADY,
    input  logic                        HRESP,
    input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic [AXI_DATA_WIDTH/8-1:0] ctrl_wdata_strb,
    output logic                        ctrl_wdata_last,
    output logic                        ctrl_wdata_valid,
    input  logic                        ctrl_wdata_ready
);
    localparam int SW     = AXI_DATA_WIDTH / 8;
    localparam int BEAT_W = AXI_DATA_WIDTH + SW + 1;
    localparam int B_W    = AXI_ID_WIDTH + 2;
    localparam int BCW    = $clog2(B_DEPTH) + 1;

    // Ready outputs stay low until the first clock after reset release.
    logic out_of_rst;

    logic [AXI_DATA_WIDTH-1:0] hd_data;
    logic [SW-1:0]             hd_strb;
    logic                      hd_last;
    logic                      beat_push, beat_pop, beat_full, beat_empty;
    logic [$clog2(WDATA_DEPTH):0] beat_count;

    logic [AXI_ID_WIDTH-1:0]   id_head;
    logic                      id_push, id_pop, id_full, id_empty;
    logic [$clog2(ID_DEPTH):0] id_count;

    logic [B_W-1:0]            b_wdata, b_head;
    logic                      b_push, b_pop, b_full, b_empty;
    logic [BCW-1:0]            b_count, b_free;

    logic                      dp_valid, dp_last, err_flag, mid_burst;
    logic [BCW-1:0]            in_flight;
    logic                      cmd_fire, id_avail, dp_stall_id, dp_done, first_pop;
    logic                      unused_sig;

    assign unused_sig = ^{beat_count, id_count, b_full};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) out_of_rst <= 1'b0;
        else          out_of_rst <= 1'b1;
    end

    // ---------------- beat FIFO ----------------
    assign WREADY    = out_of_rst && !beat_full;
    assign beat_push = WVALID && WREADY;
    assign beat_pop  = ctrl_wdata_valid && ctrl_wdata_ready;

    axi2ahb_sfifo #(.WIDTH(BEAT_W), .DEPTH(WDATA_DEPTH)) u_beat_fifo (
        .gclk(ACLK), .grst_n(ARESETN),
        .push(beat_push), .wdata({WDATA, WSTRB, WLAST}),
        .pop(beat_pop), .rdata({hd_data, hd_strb, hd_last}),
        .count(beat_count), .full(beat_full), .empty(beat_empty)
    );

    // ---------------- ID queue ----------------
    assign cmd_ready = out_of_rst && !id_full;
    assign cmd_fire  = cmd_valid && cmd_ready;
    // An ID arriving in the same cycle satisfies a waiting last beat; it is
    // then consumed directly instead of being queued.
    assign id_avail  = !id_empty || cmd_fire;
    assign id_pop    = b_push && !id_empty;
    assign id_push   = cmd_fire && !(b_push && id_empty);

    axi2ahb_sfifo #(.WIDTH(AXI_ID_WIDTH), .DEPTH(ID_DEPTH)) u_id_fifo (
        .gclk(ACLK), .grst_n(ARESETN),
        .push(id_push), .wdata(cmd_id),
        .pop(id_pop), .rdata(id_head),
        .count(id_count), .full(id_full), .empty(id_empty)
    );

    // ---------------- data phase ----------------
    // A last beat without a known ID is held in its data phase.
    assign dp_stall_id = dp_valid && dp_last && !id_avail;
    assign dp_done     = dp_valid && HREADY && !dp_stall_id;
    assign first_pop   = beat_pop && !mid_burst;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dp_valid  <= 1'b0;
            dp_last   <= 1'b0;
            HWDATA    <= '0;
            mid_burst <= 1'b0;
        end else if (beat_pop) begin
            dp_valid  <= 1'b1;
            dp_last   <= hd_last;
            HWDATA    <= hd_data;
            mid_burst <= !hd_last;
        end else if (dp_done) begin
            dp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                          err_flag <= 1'b0;
        else if (b_push)                       err_flag <= 1'b0;
        else if (dp_done && HRESP == HRESP_ERROR) err_flag <= 1'b1;
    end

    // Bursts that have started issuing but not yet produced their response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                in_flight <= '0;
        else if (first_pop && !b_push) in_flight <= in_flight + BCW'(1);
        else if (!first_pop && b_push) in_flight <= in_flight - BCW'(1);
    end

    // A new burst starts only if every started burst, plus this one, is
    // guaranteed a B slot; this keeps the B push from ever meeting a full FIFO.
    assign b_free           = BCW'(B_DEPTH) - b_count;
    assign ctrl_wdata_valid = !beat_empty && (mid_burst || (b_free > in_flight)) && !dp_stall_id;
    assign ctrl_wdata_strb  = beat_empty ? '0 : hd_strb;
    assign ctrl_wdata_last  = !beat_empty && hd_last;

    // ---------------- B FIFO ----------------
    assign b_push  = dp_done && dp_last;
    assign b_wdata = {(id_empty ? cmd_id : id_head),
                      bresp_from_err(err_flag || HRESP == HRESP_ERROR)};
    assign BVALID  = !b_empty;
    assign b_pop   = BVALID && BREADY;
    assign BID     = b_empty ? '0 : b_head[B_W-1:2];
    assign BRESP   = b_empty ? RESP_OKAY : b_head[1:0];

    axi2ahb_sfifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
        .gclk(ACLK), .grst_n(ARESETN),
        .push(b_push), .wdata(b_wdata),
        .pop(b_pop), .rdata(b_head),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

endmodule

// File: tb/tb_axi2ahb_wdata_buf.sv
// Bench for axi2ahb_wdata_buf: queue-level reference model checked every
// cycle, end-to-end data/response scoreboard, directed scenarios with
// literal expectations, then randomized traffic.
module tb_axi2ahb_wdata_buf;
    localparam int IDW = 1, DW = 32, SW = 4, WD = 8, IDD = 4, BD = 2;

    logic          ACLK = 1'b0, ARESETN = 1'b0;
    logic [DW-1:0] WDATA = '0;
    logic [SW-1:0] WSTRB = '0;
    logic          WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [IDW-1:0] BID;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY = 1'b0;
    logic [DW-1:0] HWDATA;
    logic          HREADY = 1'b1, HRESP = 1'b0;
    logic [IDW-1:0] cmd_id = '0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [SW-1:0] ctrl_wdata_strb;
    logic          ctrl_wdata_last, ctrl_wdata_valid, ctrl_wdata_ready = 1'b0;

    axi2ahb_wdata_buf #(.AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .WDATA_DEPTH(WD),
                        .ID_DEPTH(IDD), .B_DEPTH(BD)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .cmd_id(cmd_id), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .ctrl_wdata_strb(ctrl_wdata_strb), .ctrl_wdata_last(ctrl_wdata_last),
        .ctrl_wdata_valid(ctrl_wdata_valid), .ctrl_wdata_ready(ctrl_wdata_ready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed { logic [DW-1:0] d; logic [SW-1:0] s; logic l; } beat_t;
    typedef struct packed { logic [IDW-1:0] id; logic [1:0] r; } bresp_t;

    // stimulus queues and model state
    beat_t          wsend[$], wq[$];
    logic [IDW-1:0] csend[$], idq[$];
    bresp_t         bq[$];
    logic [DW-1:0]  gold_w[$];
    logic           rdy, dp_v, dp_l, mid, err;
    logic [DW-1:0]  dp_d;
    int             infl;
    logic           w_en = 1'b0, c_en = 1'b0, ctrl_en = 1'b0;

    // per-step observations
    logic           ev_done, ev_bpush, ev_bhs, ev_wacc, ev_bvalid;
    logic [DW-1:0]  ev_hw;
    logic [IDW-1:0] ev_bid;
    logic [1:0]     ev_bresp;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        wsend.delete(); wq.delete(); csend.delete(); idq.delete(); bq.delete(); gold_w.delete();
        rdy = 0; dp_v = 0; dp_l = 0; mid = 0; err = 0; dp_d = '0; infl = 0;
    endtask

    task automatic add_burst(input logic [IDW-1:0] id, input int len,
                             input logic [DW-1:0] base, input logic [SW-1:0] strb);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = DW'(base * DW'(i + 1));
            b.s = strb;
            b.l = (i == len - 1);
            wsend.push_back(b);
        end
        csend.push_back(id);
    endtask

    // One clock cycle: drive, compare against model, advance model.
    task automatic step();
        beat_t  nb, hb;
        bresp_t bh, nbr;
        logic   e_wr, e_cr, e_bv, e_cv, id_av, stall;
        logic   w_acc, c_acc, pop, done, bpush, bpop, byp;
        nb = '0; hb = '0; bh = '0; nbr = '0;
        if (wsend.size() > 0) nb = wsend[0];
        WVALID = (wsend.size() > 0) && w_en;
        WDATA = nb.d; WSTRB = nb.s; WLAST = nb.l;
        cmd_valid = (csend.size() > 0) && c_en;
        cmd_id = (csend.size() > 0) ? csend[0] : '0;
        ctrl_wdata_ready = HREADY && ctrl_en;
        #1;
        if (wq.size() > 0) hb = wq[0];
        if (bq.size() > 0) bh = bq[0];
        e_wr  = rdy && (wq.size() < WD);
        e_cr  = rdy && (idq.size() < IDD);
        e_bv  = bq.size() > 0;
        id_av = (idq.size() > 0) || (cmd_valid && e_cr);
        stall = dp_v && dp_l && !id_av;
        e_cv  = (wq.size() > 0) && (mid || ((BD - bq.size()) > infl)) && !stall;

        chk("wready", WREADY, e_wr);
        chk("cmd_ready", cmd_ready, e_cr);
        chk("bvalid", BVALID, e_bv);
        chk("bid", BID, bh.id);
        chk("bresp", BRESP, bh.r);
        chk("hwdata", HWDATA, dp_d);
        chk("ctrl_valid", ctrl_wdata_valid, e_cv);
        chk("ctrl_strb", ctrl_wdata_strb, hb.s);
        chk("ctrl_last", ctrl_wdata_last, hb.l);

        w_acc = WVALID && e_wr;
        c_acc = cmd_valid && e_cr;
        pop   = e_cv && ctrl_wdata_ready;
        done  = dp_v && HREADY && !stall;
        bpush = done && dp_l;
        bpop  = e_bv && BREADY;
        byp   = bpush && (idq.size() == 0);

        if (done && gold_w.size() > 0) chk("hwdata_order", HWDATA, gold_w.pop_front());

        ev_done = done; ev_bpush = bpush; ev_bhs = bpop; ev_wacc = w_acc;
        ev_bvalid = BVALID; ev_hw = HWDATA; ev_bid = BID; ev_bresp = BRESP;

        if (bpush) begin
            if (byp) nbr.id = cmd_id;
            else     nbr.id = idq.pop_front();
            nbr.r = (err || HRESP) ? 2'b10 : 2'b00;
        end
        if (bpop)  bq.delete(0);
        if (bpush) bq.push_back(nbr);
        if (c_acc) begin
            if (!byp) idq.push_back(cmd_id);
            csend.delete(0);
        end
        if (bpush)              err = 0;
        else if (done && HRESP) err = 1;
        if (pop) begin
            if (!mid) infl++;
            mid = !hb.l; dp_v = 1; dp_d = hb.d; dp_l = hb.l;
            wq.delete(0);
        end else if (done) dp_v = 0;
        if (bpush) infl--;
        if (w_acc) begin
            wq.push_back(wsend[0]);
            gold_w.push_back(wsend[0].d);
            wsend.delete(0);
        end
        rdy = 1;
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        w_en = 1; c_en = 1; ctrl_en = 1; HREADY = 1; HRESP = 0; BREADY = 1;
        while ((wsend.size() + csend.size() + wq.size() + idq.size() + bq.size() > 0 || dp_v) && n < 200) begin
            step();
            n++;
        end
        chk({nm, "_drained"}, (n < 200), 1'b1);
    endtask

    initial begin
        logic [DW-1:0] hw[$];
        logic [2:0]    rl[$];
        logic [DW-1:0] exp_hw [4];
        int t_last, t_bv, nd, low, n3, acc, np, nbv;
        logic [IDW-1:0] bid1;
        logic [1:0]     bresp1;

        model_reset();
        @(negedge ACLK); #1;
        chk("rst_wready", WREADY, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_ctrl_valid", ctrl_wdata_valid, 0);
        chk("rst_hwdata", HWDATA, 0);
        ARESETN = 1;
        w_en = 1; c_en = 1; ctrl_en = 1; HREADY = 1;
        step();
        chk("wready_after_release", WREADY, 1);
        chk("cmd_ready_after_release", cmd_ready, 1);

        // 4-beat burst, ID 1, no wait states
        add_burst(1, 4, 32'h11111111, 4'hf);
        BREADY = 0; t_last = -1; t_bv = -1; bid1 = '0; bresp1 = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_done) hw.push_back(ev_hw);
            if (ev_bpush) t_last = i;
            if (ev_bvalid && t_bv < 0) begin t_bv = i; bid1 = ev_bid; bresp1 = ev_bresp; end
        end
        exp_hw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        chk("burst_beats", hw.size(), 4);
        for (int k = 0; k < 4; k++) chk("burst_hwdata_seq", (hw.size() > k) ? hw[k] : '0, exp_hw[k]);
        chk("b_latency", 64'(t_bv - t_last), 1);
        chk("burst_bid", bid1, 1);
        chk("burst_bresp", bresp1, 2'b00);
        drain("okay");

        // error on second beat, following burst must be OKAY
        add_burst(1, 4, 32'h01000001, 4'hf);
        add_burst(0, 4, 32'h02000002, 4'h3);
        nd = 0; BREADY = 1;
        for (int i = 0; i < 40; i++) begin
            HRESP = (nd == 1);
            step();
            if (ev_done) nd++;
            if (ev_bhs) rl.push_back({ev_bid, ev_bresp});
        end
        HRESP = 0;
        chk("err_resp_count", rl.size(), 2);
        chk("err_resp_first", (rl.size() > 0) ? rl[0] : 3'b000, 3'b110);
        chk("err_resp_second", (rl.size() > 1) ? rl[1] : 3'b111, 3'b000);
        drain("err");

        // HREADY low for 3 cycles during beat 3
        add_burst(0, 4, 32'h01010101, 4'hf);
        nd = 0; low = 0; n3 = 0;
        for (int i = 0; i < 20; i++) begin
            HREADY = !(nd == 2 && low < 3);
            if (!HREADY) low++;
            step();
            if (ev_done) nd++;
            if (ev_hw == 32'h03030303) n3++;
        end
        chk("wait_hold_cycles", n3, 4);
        chk("wait_all_done", nd, 4);
        drain("wait");

        // fill the beat FIFO with no issue
        ctrl_en = 0; acc = 0;
        add_burst(1, 10, 32'h00000100, 4'hf);
        for (int i = 0; i < 14; i++) begin
            step();
            acc += int'(ev_wacc);
        end
        chk("full_accepted", acc, 8);
        chk("full_wready", WREADY, 0);
        ctrl_en = 1;
        step();
        ctrl_en = 0;
        chk("full_wready_resume", WREADY, 1);
        drain("full");

        // B FIFO full blocks the third burst
        BREADY = 0; np = 0;
        add_burst(0, 1, 32'h0a0a0a0a, 4'h1);
        add_burst(1, 1, 32'h0b0b0b0b, 4'h2);
        add_burst(0, 1, 32'h0c0c0c0c, 4'h4);
        for (int i = 0; i < 12; i++) begin
            step();
            np += int'(ev_bpush);
        end
        chk("bfull_pushes", np, 2);
        chk("bfull_ctrl_valid_held", ctrl_wdata_valid, 0);
        BREADY = 1;
        step();
        chk("bfull_ctrl_valid_resume", ctrl_wdata_valid, 1);
        drain("bfull");

        // reset in the middle of a burst with a response pending
        BREADY = 0;
        add_burst(0, 1, 32'h0d0d0d0d, 4'hf);
        add_burst(1, 4, 32'h00e00e00, 4'hf);
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_bvalid", BVALID, 1);
        #2 ARESETN = 0;
        #1;
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_ctrl_valid", ctrl_wdata_valid, 0);
        chk("mid_rst_ctrl_last", ctrl_wdata_last, 0);
        chk("mid_rst_ctrl_strb", ctrl_wdata_strb, 0);
        chk("mid_rst_hwdata", HWDATA, 0);
        chk("mid_rst_bid", BID, 0);
        chk("mid_rst_bresp", BRESP, 0);
        model_reset();
        @(negedge ACLK); #1;
        ARESETN = 1; BREADY = 1; nbv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nbv += int'(ev_bvalid);
        end
        chk("post_rst_no_bvalid", nbv, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (wsend.size() < 12 && $urandom_range(0, 3) == 0)
                add_burst(IDW'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom, SW'($urandom));
            w_en    = ($urandom_range(0, 3) != 0);
            c_en    = ($urandom_range(0, 2) != 0);
            HREADY  = ($urandom_range(0, 3) != 0);
            HRESP   = ($urandom_range(0, 7) == 0);
            BREADY  = ($urandom_range(0, 2) != 0);
            ctrl_en = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand");
        chk("rand_data_all_written", gold_w.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
